// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder_pkg                                                         |
// | Access-type codes, MMIO offsets and size/lane helpers for the data memory. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    DM_WORD              = 3'b000,
    DM_HALFWORD          = 3'b001,
    DM_HALFWORD_UNSIGNED = 3'b010,
    DM_BYTE              = 3'b011,
    DM_BYTE_UNSIGNED     = 3'b100
  } dm_type_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  localparam logic [5:0] c_ofs_led    = 6'h00;
  localparam logic [5:0] c_ofs_sw     = 6'h04;
  localparam logic [5:0] c_ofs_tcount = 6'h08;
  localparam logic [5:0] c_ofs_tcmp   = 6'h0C;
  localparam logic [5:0] c_ofs_tstat  = 6'h10;

  // Undefined type codes behave as word accesses.
  function automatic acc_size_e dm_size(input logic [2:0] dmtype);
    case (dmtype)
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: return SZ_HALF;
      DM_BYTE, DM_BYTE_UNSIGNED:         return SZ_BYTE;
      default:                           return SZ_WORD;
    endcase
  endfunction

  function automatic logic dm_misaligned(input logic [2:0] dmtype, input logic [1:0] lo);
    case (dm_size(dmtype))
      SZ_WORD: return (lo != 2'b00);
      SZ_HALF: return lo[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] dm_byte_en(input logic [2:0] dmtype, input logic [1:0] lo);
    case (dm_size(dmtype))
      SZ_WORD: return 4'b1111;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b0001 << lo;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_ext.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_load_ext                                                              |
// | Load lane select and sign/zero extension; purely combinational.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module dmem_load_ext
  import dmem_responder_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_dmtype,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_word >> {i_lane, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_dmtype)
      DM_HALFWORD:          o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      DM_HALFWORD_UNSIGNED: o_data = {16'b0, w_shifted[15:0]};
      DM_BYTE:              o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      DM_BYTE_UNSIGNED:     o_data = {24'b0, w_shifted[7:0]};
      default:              o_data = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder                                                             |
// | MEM-stage data responder: word RAM plus LED/SW/timer MMIO page.            |
// | Optional timer enabled by defining DMEM_TIMER_EN.                          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic        mem_r,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic [2:0]  DMType,
  output logic [31:0] Data_out,
  output logic        misalign,
  input  logic [15:0] sw_i,
  output logic [15:0] led_o,
  output logic        timer_irq
);

  localparam int          c_aw        = $clog2(DEPTH);
  localparam logic [32:0] c_ram_bytes = 33'(DEPTH) << 2;

  logic [31:0]     r_mem [DEPTH];
  logic [15:0]     r_led;
  logic [15:0]     r_sw_meta;
  logic [15:0]     r_sw_sync;

  logic            w_misalign;
  logic            w_ram_sel;
  logic            w_mmio_sel;
  logic            w_wr_ok;
  logic            w_mmio_wr;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_mmio_rdata;
  logic [31:0]     w_rd_word;
  logic [31:0]     w_load_data;
  logic [c_aw-1:0] w_idx;

  assign w_misalign = (mem_r | mem_w) & dm_misaligned(DMType, Addr_in[1:0]);
  assign w_ram_sel  = ({1'b0, Addr_in} < c_ram_bytes);
  assign w_mmio_sel = (Addr_in[31:6] == MMIO_BASE[31:6]);
  assign w_idx      = Addr_in[c_aw+1:2];
  assign w_wr_ok    = mem_w & ~w_misalign;
  assign w_be       = dm_byte_en(DMType, Addr_in[1:0]);
  assign w_wdata    = Data_in << {Addr_in[1:0], 3'b000};
  assign w_mmio_wr  = w_wr_ok & w_mmio_sel & (dm_size(DMType) == SZ_WORD);

  // RAM ignores reset on purpose: a store in flight during reset still lands.
  always_ff @(posedge clk) begin
    if (w_wr_ok && w_ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_i;
      r_sw_sync <= r_sw_meta;
      if (w_mmio_wr && (Addr_in[5:0] == c_ofs_led)) r_led <= Data_in[15:0];
    end
  end

  assign led_o = r_led;

`ifdef DMEM_TIMER_EN
  logic [31:0] r_tcount;
  logic [31:0] r_tcmp;
  logic        r_tstat_irq;
  logic        r_tstat_en;
  logic        w_match;
  logic        w_wr_tcount;
  logic        w_wr_tcmp;
  logic        w_wr_tstat;

  assign w_match     = r_tstat_en & (r_tcount == r_tcmp);
  assign w_wr_tcount = w_mmio_wr & (Addr_in[5:0] == c_ofs_tcount);
  assign w_wr_tcmp   = w_mmio_wr & (Addr_in[5:0] == c_ofs_tcmp);
  assign w_wr_tstat  = w_mmio_wr & (Addr_in[5:0] == c_ofs_tstat);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcount    <= '0;
      r_tcmp      <= '0;
      r_tstat_irq <= 1'b0;
      r_tstat_en  <= 1'b0;
    end else begin
      if (w_wr_tcount)     r_tcount <= Data_in;
      else if (w_match)    r_tcount <= '0;
      else if (r_tstat_en) r_tcount <= r_tcount + 32'd1;
      if (w_wr_tcmp)  r_tcmp     <= Data_in;
      if (w_wr_tstat) r_tstat_en <= Data_in[1];
      // A match in the same cycle as a write-1-clear keeps the flag set.
      r_tstat_irq <= w_match | (r_tstat_irq & ~(w_wr_tstat & Data_in[0]));
    end
  end

  assign timer_irq = r_tstat_irq;
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    w_mmio_rdata = '0;
    case (Addr_in[5:0])
      c_ofs_led:    w_mmio_rdata = {16'b0, r_led};
      c_ofs_sw:     w_mmio_rdata = {16'b0, r_sw_sync};
`ifdef DMEM_TIMER_EN
      c_ofs_tcount: w_mmio_rdata = r_tcount;
      c_ofs_tcmp:   w_mmio_rdata = r_tcmp;
      c_ofs_tstat:  w_mmio_rdata = {30'b0, r_tstat_en, r_tstat_irq};
`endif
      default:      w_mmio_rdata = '0;
    endcase
  end

  always_comb begin
    w_rd_word = '0;
    if (w_ram_sel)       w_rd_word = r_mem[w_idx];
    else if (w_mmio_sel) w_rd_word = w_mmio_rdata;
  end

  dmem_load_ext u_load_ext (
    .i_word   (w_rd_word),
    .i_lane   (Addr_in[1:0]),
    .i_dmtype (DMType),
    .o_data   (w_load_data)
  );

  assign Data_out = (mem_r && !w_misalign) ? w_load_data : 32'd0;
  assign misalign = w_misalign;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_responder                                                          |
// | Self-checking bench: byte-addressed reference model plus directed cases.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

  localparam logic [31:0] MB   = 32'hFFFF0000;
  localparam logic [2:0]  T_W  = 3'd0;
  localparam logic [2:0]  T_H  = 3'd1;
  localparam logic [2:0]  T_HU = 3'd2;
  localparam logic [2:0]  T_B  = 3'd3;
  localparam logic [2:0]  T_BU = 3'd4;
  localparam logic [31:0] RBASE = 32'h200;

  logic        clk = 1'b0;
  logic        reset, mem_w, mem_r;
  logic [31:0] Addr_in, Data_in, Data_out;
  logic [2:0]  DMType;
  logic        misalign, timer_irq;
  logic [15:0] sw_i, led_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mb [64];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .MMIO_BASE(MB)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .mem_r(mem_r),
    .Addr_in(Addr_in), .Data_in(Data_in), .DMType(DMType),
    .Data_out(Data_out), .misalign(misalign),
    .sw_i(sw_i), .led_o(led_o), .timer_irq(timer_irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    Addr_in = a; Data_in = d; DMType = t; mem_w = 1'b1; mem_r = 1'b0;
    step();
    mem_w = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] t,
                         output logic [31:0] d, output logic mis);
    Addr_in = a; DMType = t; mem_r = 1'b1; mem_w = 1'b0;
    #2;
    d = Data_out; mis = misalign;
    step();
    mem_r = 1'b0;
  endtask

  function automatic int size_of(input logic [2:0] t);
    if (t == T_B || t == T_BU) return 1;
    if (t == T_H || t == T_HU) return 2;
    return 4;
  endfunction

  // Reference load from the byte model: little-endian gather then extend.
  function automatic logic [31:0] model_load(input int off, input logic [2:0] t);
    logic [31:0] v = 0;
    for (int k = 0; k < size_of(t); k++) v = v + (32'(mb[off+k]) << (8*k));
    if (t == T_B && v >= 128)   v = v + 32'hFFFFFF00;
    if (t == T_H && v >= 32768) v = v + 32'hFFFF0000;
    return v;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; mem_w = 0; mem_r = 0; Addr_in = 32'h2; Data_in = 0; DMType = T_W; sw_i = 0;
    step(); step();
    checks++; if (led_o !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=0000", led_o); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
    checks++; if (Data_out !== 32'h0) begin failures++; $display("FAIL idle_data got=%h exp=0", Data_out); end
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL idle_misalign got=%b exp=0", misalign); end
    reset = 1'b0;
    step();
    d = 0;
  endtask

  task automatic test_spec_vectors();
    logic [31:0] d; logic m;
    do_store(32'h10, 32'h12345678, T_W);
    do_load(32'h13, T_B, d, m);
    checks++; if (d !== 32'h12) begin failures++; $display("FAIL byte_0x13 got=%h exp=00000012", d); end
    do_load(32'h12, T_HU, d, m);
    checks++; if (d !== 32'h1234) begin failures++; $display("FAIL halfu_0x12 got=%h exp=00001234", d); end
    do_store(32'h20, 32'h11223344, T_W);
    do_store(32'h21, 32'h00000080, T_B);
    do_load(32'h21, T_B, d, m);
    checks++; if (d !== 32'hFFFFFF80) begin failures++; $display("FAIL sbyte_0x21 got=%h exp=ffffff80", d); end
    do_load(32'h20, T_W, d, m);
    checks++; if (d !== 32'h11228044) begin failures++; $display("FAIL lane1_only got=%h exp=11228044", d); end
    Addr_in = 32'h22; Data_in = 32'hDEADBEEF; DMType = T_W; mem_w = 1'b1;
    #2;
    checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL misalign_store got=%b exp=1", misalign); end
    step(); mem_w = 1'b0;
    do_load(32'h20, T_W, d, m);
    checks++; if (d !== 32'h11228044) begin failures++; $display("FAIL misalign_suppress got=%h exp=11228044", d); end
    do_load(32'h21, T_H, d, m);
    checks++; if (d !== 32'h0 || m !== 1'b1) begin failures++; $display("FAIL misalign_load got=%h/%b exp=0/1", d, m); end
  endtask

  task automatic test_boundary();
    logic [31:0] d; logic m;
    do_store(32'hFFC, 32'hA5A5C3C3, T_W);
    do_load(32'hFFC, T_W, d, m);
    checks++; if (d !== 32'hA5A5C3C3) begin failures++; $display("FAIL last_word got=%h exp=a5a5c3c3", d); end
    do_store(32'h0, 32'h01020304, T_W);
    do_store(32'h1000, 32'hFFFFFFFF, T_W);
    do_load(32'h0, T_W, d, m);
    checks++; if (d !== 32'h01020304) begin failures++; $display("FAIL no_alias got=%h exp=01020304", d); end
    do_load(32'h1000, T_W, d, m);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_ram got=%h exp=0", d); end
    do_load(MB + 32'h20, T_W, d, m);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_mmio got=%h exp=0", d); end
  endtask

  task automatic test_read_during_write();
    logic [31:0] d; logic m;
    do_store(32'h300, 32'hAAAA5555, T_W);
    Addr_in = 32'h300; Data_in = 32'h0F0F0F0F; DMType = T_W; mem_w = 1'b1; mem_r = 1'b1;
    #2;
    checks++; if (Data_out !== 32'hAAAA5555) begin failures++; $display("FAIL rdw_old got=%h exp=aaaa5555", Data_out); end
    step(); mem_w = 0; mem_r = 0;
    do_load(32'h300, T_W, d, m);
    checks++; if (d !== 32'h0F0F0F0F) begin failures++; $display("FAIL rdw_new got=%h exp=0f0f0f0f", d); end
  endtask

  task automatic test_random_ram();
    logic [31:0] d, exp_d; logic [2:0] t; int off, op; logic exp_m;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      do_store(RBASE + 32'(4*w), d, T_W);
      for (int k = 0; k < 4; k++) mb[4*w+k] = d[8*k +: 8];
    end
    for (int n = 0; n < 300; n++) begin
      op  = $urandom_range(0, 2);
      off = $urandom_range(0, 63);
      t   = 3'($urandom_range(0, 4));
      d   = $urandom;
      exp_m = ((off % size_of(t)) != 0);
      if (off + size_of(t) > 64) exp_m = 1'b1;
      exp_d = exp_m ? 32'h0 : model_load(off, t);
      Addr_in = RBASE + 32'(off); Data_in = d; DMType = t;
      mem_w = (op != 1); mem_r = (op != 0);
      #2;
      checks++;
      if (misalign !== exp_m) begin failures++; $display("FAIL rnd_misalign op=%0d off=%0d t=%0d got=%b exp=%b", op, off, t, misalign, exp_m); end
      if (op != 0) begin
        checks++;
        if (Data_out !== exp_d) begin failures++; $display("FAIL rnd_load op=%0d off=%0d t=%0d got=%h exp=%h", op, off, t, Data_out, exp_d); end
      end
      step(); mem_w = 0; mem_r = 0;
      if (op != 1 && !exp_m)
        for (int k = 0; k < size_of(t); k++) mb[off+k] = d[8*k +: 8];
    end
    for (int w = 0; w < 16; w++) begin
      logic m;
      do_load(RBASE + 32'(4*w), T_W, d, m);
      exp_d = model_load(4*w, T_W);
      checks++; if (d !== exp_d) begin failures++; $display("FAIL rnd_final w=%0d got=%h exp=%h", w, d, exp_d); end
    end
  endtask

  task automatic test_led();
    logic [31:0] d; logic m;
    do_store(MB, 32'h0000ABCD, T_W);
    checks++; if (led_o !== 16'hABCD) begin failures++; $display("FAIL led_write got=%h exp=abcd", led_o); end
    do_store(MB, 32'h00000055, T_B);
    checks++; if (led_o !== 16'hABCD) begin failures++; $display("FAIL led_subword_drop got=%h exp=abcd", led_o); end
    do_load(MB, T_W, d, m);
    checks++; if (d !== 32'h0000ABCD) begin failures++; $display("FAIL led_read got=%h exp=0000abcd", d); end
    do_store(32'h40, 32'h11111111, T_W);
    reset = 1'b1;
    do_store(MB, 32'h00001234, T_W);
    checks++; if (led_o !== 16'h0) begin failures++; $display("FAIL led_reset got=%h exp=0000", led_o); end
    do_store(32'h40, 32'hCAFEF00D, T_W);
    reset = 1'b0;
    do_load(32'h40, T_W, d, m);
    checks++; if (d !== 32'hCAFEF00D) begin failures++; $display("FAIL ram_commit_in_reset got=%h exp=cafef00d", d); end
  endtask

  task automatic test_sw_sync();
    sw_i = 16'h00F0; Addr_in = MB + 32'h4; DMType = T_W; mem_r = 1'b1;
    #2;
    checks++; if (Data_out !== 32'h0) begin failures++; $display("FAIL sw_edge0 got=%h exp=0", Data_out); end
    step(); #2;
    checks++; if (Data_out !== 32'h0) begin failures++; $display("FAIL sw_edge1 got=%h exp=0", Data_out); end
    step(); #2;
    checks++; if (Data_out !== 32'h00F0) begin failures++; $display("FAIL sw_edge2 got=%h exp=000000f0", Data_out); end
    step(); mem_r = 1'b0;
  endtask

  task automatic test_timer();
    logic [31:0] d; logic m;
    do_store(MB + 32'hC, 32'd3, T_W);
    do_store(MB + 32'h10, 32'h2, T_W);
`ifdef DMEM_TIMER_EN
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (timer_irq !== (k == 4)) begin failures++; $display("FAIL timer_edge%0d got=%b exp=%b", k, timer_irq, (k == 4)); end
    end
    do_load(MB + 32'h8, T_W, d, m);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL tcount_wrap got=%h exp=0", d); end
    do_store(MB + 32'h10, 32'h1, T_W);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", timer_irq); end
    do_store(MB + 32'h8, 32'd7, T_W);
    do_load(MB + 32'h8, T_W, d, m);
    checks++; if (d !== 32'd7) begin failures++; $display("FAIL tcount_write got=%h exp=7", d); end
`else
    for (int k = 0; k < 5; k++) step();
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_tied got=%b exp=0", timer_irq); end
    do_load(MB + 32'hC, T_W, d, m);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL tcmp_unmapped got=%h exp=0", d); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spec_vectors();
    test_boundary();
    test_read_during_write();
    test_random_ram();
    test_led();
    test_sw_sync();
    test_timer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
